serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_tx_if.sv | 30 +++
 rtl/serial_tx_bit_timer.sv | 31 +++
 rtl/serial_tx.sv | 114 +++++++++++
 tb/tb_serial_tx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its companion receiver:
// FSM state encoding and the frame-shape constants.
package serial_pkg;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Number of bit periods in one frame, with or without the parity bit.
    function automatic int frame_bits(input bit parity_en);
        return START_BITS + DATA_BITS + (parity_en ? 1 : 0) + STOP_BITS;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Byte-in / serial-out bus of the transmitter.
// Handshake: a byte moves on a posedge where valid_in and ready_out are both 1
// (and clear is 0). The producer keeps data_in stable while valid_in is high
// and ready_out is low; ready_out never depends combinationally on valid_in.
interface serial_tx_if;
    import serial_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 valid_in;
    logic                 ready_out;
    logic                 tx_out;
    logic                 busy;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output tx_out,
        output busy
    );

endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick in
// the last cycle of each bit period, wrapping back to 0 on that cycle.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_count;

    assign tick = enable && (r_count == LAST_COUNT);

    // Advance the count while a frame is in progress; wrap at the bit boundary.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_count <= 8'd0;
        end else if (enable) begin
            if (tick) begin
                r_count <= 8'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, optional
// even parity, one stop bit. The line idles high and is always register-driven.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic        clock,
    input  logic        clear,
    serial_tx_if.slave  bus,
    output tx_state_t   o_dbg_state
);

    tx_state_t            r_state;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_shreg;
    logic [2:0]           r_bit_idx;

    logic                 w_tick;
    logic                 w_timer_en;
    logic                 w_accept;
    logic [2:0]           w_next_idx;

    assign w_timer_en = (r_state != IDLE);
    assign w_accept   = bus.valid_in && r_ready;
    assign w_next_idx = r_bit_idx + 3'd1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock (clock),
        .clear (clear),
        .enable(w_timer_en),
        .tick  (w_tick)
    );

    // Frame sequencer; tx_out, ready_out and busy are all set here as registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_shreg   <= '0;
            r_bit_idx <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_shreg   <= bus.data_in;
                        r_bit_idx <= 3'd0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN) begin
                                r_state <= PARITY;
                                r_tx    <= ^r_shreg;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shreg[w_next_idx];
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    // Returning to IDLE guarantees one ready cycle between frames.
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_tx      <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_bit_idx <= 3'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out    = r_tx;
    assign bus.ready_out = r_ready;
    assign bus.busy      = r_busy;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (4 clk/bit with parity, 4 clk/bit
// without parity, 1 clk/bit with parity), a frame-level model per instance and
// directed frames with hand-written expected bit patterns and lengths.
module tb_serial_tx;
    import serial_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic chk_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- per-instance stimulus and observed outputs ----------------
    logic [7:0] data_r [3];
    logic [2:0] valid_r;
    logic [2:0] clear_r;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] ready_w;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int cpb(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    // ---------------- instances, model and per-cycle compare ----------------
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int C = (g == 2) ? 1 : 4;
        localparam bit P = (g == 1) ? 1'b0 : 1'b1;

        serial_tx_if u_if();
        tx_state_t   dbg_state;
        logic [0:0]  exp_q[$];
        logic [10:0] fr;
        int          nb;
        logic        was_idle;

        assign u_if.data_in  = data_r[g];
        assign u_if.valid_in = valid_r[g];
        assign tx_w[g]       = u_if.tx_out;
        assign busy_w[g]     = u_if.busy;
        assign ready_w[g]    = u_if.ready_out;

        serial_tx #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   (P)
        ) u_dut (
            .clock      (clk),
            .clear      (clear_r[g]),
            .bus        (u_if.slave),
            .o_dbg_state(dbg_state)
        );

        // Model: an accepted byte becomes a queue of line levels, one entry
        // per clock; an empty queue means the line is idle.
        always @(posedge clk) begin
            was_idle = (exp_q.size() == 0);
            if (clear_r[g]) begin
                exp_q.delete();
            end else if (!was_idle) begin
                void'(exp_q.pop_front());
            end else if (valid_r[g]) begin
                if (P) begin
                    fr = {1'b1, ^data_r[g], data_r[g], 1'b0};
                    nb = 11;
                end else begin
                    fr = {1'b1, 1'b1, data_r[g], 1'b0};
                    nb = 10;
                end
                for (int i = 0; i < nb; i++) begin
                    for (int j = 0; j < C; j++) exp_q.push_back(fr[i]);
                end
            end
        end

        always @(negedge clk) begin
            if (chk_on) begin
                if (exp_q.size() > 0) begin
                    check($sformatf("u%0d_tx", g),    32'(tx_w[g]),    32'(exp_q[0]));
                    check($sformatf("u%0d_busy", g),  32'(busy_w[g]),  32'd1);
                    check($sformatf("u%0d_ready", g), 32'(ready_w[g]), 32'd0);
                end else begin
                    check($sformatf("u%0d_tx_idle", g),    32'(tx_w[g]),    32'd1);
                    check($sformatf("u%0d_busy_idle", g),  32'(busy_w[g]),  32'd0);
                    check($sformatf("u%0d_ready_idle", g), 32'(ready_w[g]), 32'd1);
                    check($sformatf("u%0d_state_idle", g), 32'(dbg_state),  32'(IDLE));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge while the instance is idle; returns at the negedge
    // of the first frame cycle.
    task automatic send(input int k, input logic [7:0] d);
        valid_r[k] = 1'b1;
        data_r[k]  = d;
        @(posedge clk);
        @(negedge clk);
        valid_r[k] = 1'b0;
    endtask

    // Called at the negedge of frame cycle 0; records tx at mid-bit for each
    // bit period and the number of busy cycles. Returns at the first idle negedge.
    task automatic capture(input int k, output logic [10:0] bits, output int len);
        int n;
        n    = cpb(k);
        bits = '1;
        len  = 0;
        while (busy_w[k] === 1'b1 && len < 200) begin
            if ((len % n) == (n / 2) && (len / n) < 11) bits[len / n] = tx_w[k];
            len++;
            @(negedge clk);
        end
        if (len >= 200) check($sformatf("u%0d_frame_timeout", k), 32'(len), 32'd0);
    endtask

    task automatic check_idle_now(input string name, input int k);
        check({name, "_tx"},    32'(tx_w[k]),    32'd1);
        check({name, "_busy"},  32'(busy_w[k]),  32'd0);
        check({name, "_ready"}, 32'(ready_w[k]), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [10:0] bits;
        int          len;

        n_checks = 0;
        n_fail   = 0;
        chk_on   = 1'b0;
        valid_r  = '0;
        clear_r  = '1;
        for (int i = 0; i < 3; i++) data_r[i] = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_r = '0;
        chk_on  = 1'b1;
        for (int i = 0; i < 3; i++) check_idle_now($sformatf("reset_u%0d", i), i);
        @(negedge clk);

        // A5 with parity: start, A5 LSB first, parity 0, stop; 44 cycles.
        send(0, 8'hA5);
        capture(0, bits, len);
        check("a5_bits", 32'(bits), 32'(11'b101_0100_1010));
        check("a5_len",  32'(len),  32'd44);

        // Parity of FF is 0, parity of 01 is 1.
        send(0, 8'hFF);
        capture(0, bits, len);
        check("ff_parity", 32'(bits[9]), 32'd0);
        check("ff_bits",   32'(bits),    32'(11'b101_1111_1110));
        send(0, 8'h01);
        capture(0, bits, len);
        check("01_parity", 32'(bits[9]), 32'd1);
        check("01_len",    32'(len),     32'd44);

        // No parity: 01 gives a 40-cycle frame, stop directly after bit 7.
        send(1, 8'h01);
        capture(1, bits, len);
        check("np01_bits", 32'(bits[9:0]), 32'(10'b10_0000_0010));
        check("np01_len",  32'(len),        32'd40);

        // Clear for one cycle at frame cycle 17, then a clean 3C frame.
        send(0, 8'h55);
        repeat (17) @(negedge clk);
        clear_r[0] = 1'b1;
        @(negedge clk);
        clear_r[0] = 1'b0;
        check_idle_now("abort", 0);
        @(negedge clk);
        check_idle_now("abort_hold", 0);
        send(0, 8'h3C);
        capture(0, bits, len);
        check("3c_bits", 32'(bits), 32'(11'b100_0111_1000));
        check("3c_len",  32'(len),  32'd44);

        // valid held high, data changed mid-frame: C3 unchanged, one idle
        // cycle, then a frame of 00.
        valid_r[0] = 1'b1;
        data_r[0]  = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        data_r[0]  = 8'h00;
        capture(0, bits, len);
        check("c3_bits", 32'(bits), 32'(11'b101_1000_0110));
        check("c3_len",  32'(len),  32'd44);
        check_idle_now("c3_gap", 0);
        @(negedge clk);
        valid_r[0] = 1'b0;
        check("reaccept_busy", 32'(busy_w[0]), 32'd1);
        capture(0, bits, len);
        check("00_bits", 32'(bits), 32'(11'b100_0000_0000));
        check("00_len",  32'(len),  32'd44);

        // One clock per bit: 80 then 7F back to back, 11 cycles each.
        valid_r[2] = 1'b1;
        data_r[2]  = 8'h80;
        @(posedge clk);
        @(negedge clk);
        data_r[2]  = 8'h7F;
        capture(2, bits, len);
        check("80_bits", 32'(bits), 32'(11'b111_0000_0000));
        check("80_len",  32'(len),  32'd11);
        check_idle_now("b2b_gap", 2);
        @(negedge clk);
        valid_r[2] = 1'b0;
        capture(2, bits, len);
        check("7f_bits", 32'(bits), 32'(11'b110_1111_1110));
        check("7f_len",  32'(len),  32'd11);

        // clear and valid on the same edge: nothing starts.
        clear_r[0] = 1'b1;
        valid_r[0] = 1'b1;
        data_r[0]  = 8'hAA;
        @(negedge clk);
        clear_r[0] = 1'b0;
        valid_r[0] = 1'b0;
        check_idle_now("clr_vs_valid", 0);
        repeat (3) @(negedge clk);
        check_idle_now("clr_vs_valid_hold", 0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
